// File: rtl/lif_neuron_array_cfg.sv
// ---------------------------------------------------------------------------
// lif_neuron_array_cfg
//
// Array of N leaky integrate-and-fire neurons with W-bit membrane potentials.
// Each neuron leaks by v >> LEAK_SHIFT on every time step. It adds a shared
// runtime weight when its input spike is present, and the sum saturates at
// 2^W-1. The neuron fires when the result reaches the shared runtime
// threshold. After a spike it stays silent for REFRACT steps. A saturating
// aggregate counter totals every emitted spike. A registered readout port
// shows the membrane potential of one selected neuron.
//
// Ports:
//   clk          in   1            rising-edge clock
//   reset        in   1            synchronous active-high reset, beats step
//   step         in   1            time-step strobe; neurons advance only here
//   spike_in     in   N            per-neuron input spike, sampled on step
//   weight       in   W            shared synaptic weight, sampled on step
//   threshold    in   W            shared firing threshold, sampled on step
//   v_sel        in   SW           neuron index for the membrane readout
//   spike_out    out  N            registered one-cycle spike pulses
//   spike_count  out  CW           saturating total of emitted spikes
//   v_out        out  W            registered membrane of neuron v_sel
// ---------------------------------------------------------------------------
module lif_neuron_array_cfg #(
  parameter int N          = 4,
  parameter int W          = 8,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRACT    = 2,
  parameter int CW         = 16,
  localparam int SW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          step,
  input  logic [N-1:0]  spike_in,
  input  logic [W-1:0]  weight,
  input  logic [W-1:0]  threshold,
  input  logic [SW-1:0] v_sel,
  output logic [N-1:0]  spike_out,
  output logic [CW-1:0] spike_count,
  output logic [W-1:0]  v_out
);

  // Refractory counters only need to hold 0..REFRACT. When there is no
  // refractory period, a single bit is kept that stays at zero.
  localparam int RW  = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  // Width of the per-step popcount of emitted spikes.
  localparam int PW  = $clog2(N + 1);
  // Counter addition width: wide enough for both operands plus a carry,
  // so the saturation test can never be fooled by a wrap.
  localparam int CSW = ((CW > PW) ? CW : PW) + 1;

  localparam logic [RW-1:0] REFRACT_LOAD = RW'(REFRACT);

  // Architectural state
  logic [W-1:0]  r_v     [N];
  logic [RW-1:0] r_refr  [N];
  logic [N-1:0]  r_spike;
  logic [CW-1:0] r_count;
  logic [W-1:0]  r_vOut;

  // Next-state values
  logic [W-1:0]  w_vNext    [N];
  logic [RW-1:0] w_refrNext [N];
  logic [N-1:0]  w_spikeNext;
  logic [PW-1:0] w_pop;
  logic [CSW-1:0] w_countSum;
  logic [CW-1:0] w_countNext;
  logic [W-1:0]  w_vSel;

  // One neuron's update datapath per lane. The lanes are fully independent.
  // The arithmetic is carried in W+1 bits. That way the leak never
  // underflows, and an overflow past 2^W-1 shows up in the top bit, where
  // the saturation logic can catch it. A neuron that is in refractory
  // ignores its input, keeps its membrane at zero and only counts down.
  // A firing neuron resets its membrane and reloads the refractory count.
  for (genvar g = 0; g < N; g++) begin : gNeuron
    logic [W:0]   w_leaked;
    logic [W:0]   w_sum;
    logic [W-1:0] w_vn;
    logic         w_inRefr;
    logic         w_fire;

    assign w_inRefr = (r_refr[g] != '0);
    assign w_leaked = {1'b0, r_v[g]} - ({1'b0, r_v[g]} >> LEAK_SHIFT);
    assign w_sum    = w_leaked + (spike_in[g] ? {1'b0, weight} : {(W+1){1'b0}});
    assign w_vn     = w_sum[W] ? {W{1'b1}} : w_sum[W-1:0];
    assign w_fire   = step && !w_inRefr && (w_vn >= threshold);

    assign w_spikeNext[g] = w_fire;

    assign w_vNext[g] = !step                 ? r_v[g] :
                        (w_inRefr || w_fire)  ? {W{1'b0}} :
                                                w_vn;

    assign w_refrNext[g] = !step    ? r_refr[g] :
                           w_inRefr ? r_refr[g] - RW'(1) :
                           w_fire   ? REFRACT_LOAD :
                                      {RW{1'b0}};
  end

  // Count how many neurons fire on this edge. All N lanes may fire in the
  // same step, and every one of them must land in the counter at once.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < N; i++) begin
      w_pop = w_pop + PW'(w_spikeNext[i]);
    end
  end

  // The aggregate counter sticks at its all-ones value rather than wrapping.
  // This keeps a long-running monitor from ever seeing a bogus small total.
  assign w_countSum  = CSW'(r_count) + CSW'(w_pop);
  assign w_countNext = (w_countSum > CSW'({CW{1'b1}})) ? {CW{1'b1}} : w_countSum[CW-1:0];

  // The readout mux looks at the post-update membrane values. The registered
  // v_out therefore shows the state just written at the same edge. A
  // select outside 0..N-1 matches no lane and reads as zero. This only
  // matters when N is not a power of two.
  always_comb begin
    w_vSel = '0;
    for (int i = 0; i < N; i++) begin
      if (v_sel == SW'(i)) begin
        w_vSel = w_vNext[i];
      end
    end
  end

  // Single state register for the whole array. Reset wins over step and
  // clears everything, so the first step afterwards behaves exactly like
  // the first step after power-on. Spike pulses are rebuilt every cycle.
  // This makes them single-cycle pulses, and they drop to zero on idle
  // cycles because nothing fires without a step.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        r_v[i]    <= '0;
        r_refr[i] <= '0;
      end
      r_spike <= '0;
      r_count <= '0;
      r_vOut  <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        r_v[i]    <= w_vNext[i];
        r_refr[i] <= w_refrNext[i];
      end
      r_spike <= w_spikeNext;
      r_count <= w_countNext;
      r_vOut  <= w_vSel;
    end
  end

  assign spike_out   = r_spike;
  assign spike_count = r_count;
  assign v_out       = r_vOut;

endmodule

// File: doc/lif_neuron_array_cfg.md
Name: lif_neuron_array_cfg

Overview:
- Parametrised next-generation array of N leaky integrate-and-fire neurons with W-bit membrane potentials.
- Adds a shift-based leak, a runtime weight and threshold, a refractory period, saturating integration, a time-step strobe, an aggregate spike counter and a membrane readout port.
- Sits between the spike-input fabric and downstream spike consumers and monitors in the SNN datapath.

Parameters:
- N, 4: number of neurons (1..64).
- W, 8: membrane potential, weight and threshold width in bits (4..16).
- LEAK_SHIFT, 3: leak per step is v >> LEAK_SHIFT (1..W-1).
- REFRACT, 2: refractory length in time steps after a spike (0..255; 0 means none).
- CW, 16: spike_count width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- step  in  1  time-step strobe; neuron state advances only on cycles where step=1.
- spike_in  in  N  input spike per neuron, sampled when step=1.
- weight  in  W  synaptic weight added on an input spike; shared by all neurons; sampled when step=1.
- threshold  in  W  firing threshold; shared by all neurons; sampled when step=1.
- v_sel  in  max(1,clog2(N))  neuron index for the membrane readout.
- spike_out  out  N  registered one-cycle spike pulses.
- spike_count  out  CW  saturating total of all emitted spikes.
- v_out  out  W  registered membrane potential of neuron v_sel.

Behaviour:
- Reset: takes priority over step. Clears all v[i], refr[i] (refractory counters), spike_out, spike_count and v_out to 0.
- Idle cycles (step=0): v and refr hold; spike_out=0 on the next edge; spike_count holds.
- Step cycles (step=1), per neuron i, evaluated combinationally from the current state and registered at the edge:
  - Refractory (refr[i]>0): refr[i] decrements by 1; v[i] stays 0; spike_in[i] is ignored; spike_out[i]=0.
  - Otherwise, with all arithmetic in W+1 bits:
    - leaked = v[i] - (v[i] >> LEAK_SHIFT)
    - sum = leaked + (spike_in[i] ? weight : 0)
    - vn = min(sum, 2^W-1), i.e. saturating
  - Fire if vn >= threshold: spike_out[i]=1, v[i]=0, refr[i]=REFRACT.
  - Else: spike_out[i]=0, v[i]=vn.
  - threshold=0: every non-refractory neuron fires each step.
- Latency: spike_out is visible the cycle after the step cycle that caused it, and is a 1-cycle pulse.
- spike_count: at the same edge as spike_out, adds popcount of the spikes being emitted; saturates at 2^CW-1 and never wraps.
- v_out: registered every cycle. Equals v[v_sel] as of the prior edge, so it shows state after the update.
  - v_sel >= N gives v_out=0.
- Neurons are fully independent; simultaneous spikes from all N neurons are counted in one step.
- Reset asserted mid-refractory or mid-integration fully clears state. The first step after reset deassertion behaves as from power-on.
- Runtime changes to weight or threshold take effect on the next step cycle; no retiming of state.

Test Plan:
- Integrate-and-fire, N=4 W=8 LEAK_SHIFT=3 REFRACT=2, weight=40, threshold=100, spike_in=0001 on every step:
  - v0 goes 40, 75, then 106 → spike_out[0]=1 after step 3; v0=0; spike_count=1.
- Refractory, continuing the previous case:
  - steps 4 and 5 give spike_out=0 and v0=0 despite input;
  - step 6 gives v0=40; step 8 spikes again; spike_count=2.
- Leak only, neuron 1 charged to 40 (one step, weight=40, threshold=255), then spike_in=0:
  - v1 decays 35, 31, 28, 25 on successive steps; v_out with v_sel=1 tracks it; step=0 cycles hold the value.
- Saturation, weight=200, threshold=255:
  - step 1 gives v=200; step 2 computes 200-25+200=375, saturates to 255, fires; v returns to 0.
- Simultaneous spikes and counter, spike_in=1111, weight=255, threshold=1, REFRACT=0:
  - every step gives spike_out=1111 and spike_count += 4;
  - with CW=4, the counter sticks at 15.
- Reset mid-operation: assert reset while neuron 0 has refr=1 and v2=75:
  - next cycle all outputs=0;
  - first step after deassertion with weight=40, spike_in=0101 gives v0=40 and v2=40.
